ttc_chanb_frame_decoder: RTL and testbench
==========================================

# ttc_chanb_frame_decoder

Deserializes the TTC channel B bit stream into broadcast commands for the Channel B receiver that sets fill type, pulse storage and trigger resets. Sits between the TTC biphase demultiplexer, which provides one channel B bit per strobe, and that receiver. The block:
- frames short (broadcast) and long (addressed) frames;
- checks the short-frame Hamming code;
- emits a one-cycle valid strobe with the decoded broadcast byte;
- keeps saturating error counters for status readout.

## Interface
- CNT_W, 16, width of the saturating status counters
- clk  in  1  TTC-recovered 40 MHz clock
- reset  in  1  synchronous, active-high
- b_bit  in  1  channel B serial bit, MSB first, idle line = 1
- b_strobe  in  1  b_bit is valid this cycle; bits with b_strobe=0 are ignored
- clear_counters  in  1  synchronous clear of all status counters
- chan_b_info  out  6  broadcast bits Brcst[7:2], held until next valid frame
- evt_count_reset  out  1  Brcst[1], held
- bcnt_reset  out  1  Brcst[0], held
- chan_b_valid  out  1  one-cycle strobe: new short frame decoded without error
- hamming_err_count  out  CNT_W  short frames dropped on Hamming mismatch
- stop_err_count  out  CNT_W  frames dropped on missing stop bit
- long_frame_count  out  CNT_W  long frames seen and discarded

## Operation
- Only bits with b_strobe=1 are consumed; all bit counts below are in strobed bits.
- Short frame, 16 bits: start 0, format 0, D7..D0, H4..H0, stop 1.
- Long frame, 42 bits: start 0, format 1, 39 payload bits, stop 1. The payload is not decoded.
- Hamming equations:
  - h0 = d0^d1^d2^d3
  - h1 = d0^d4^d5^d6
  - h2 = d1^d2^d4^d5^d7
  - h3 = d1^d3^d4^d6^d7
  - h4 = XOR of d0..d7 and h0..h3
- Detection only; no correction.
- FSM states:
  - IDLE: a strobed 0 goes to FMT; a 1 stays in IDLE.
  - FMT: a 0 goes to SHORT with bit counter = 0; a 1 goes to LONG with bit counter = 0.
  - SHORT: shift in 13 bits (8 data, 5 check), then go to SSTOP.
  - SSTOP: next strobed bit is the stop bit.
    - Stop = 1 and Hamming OK: load outputs, pulse chan_b_valid.
    - Stop = 1 and Hamming bad: increment hamming_err_count.
    - Stop = 0: increment stop_err_count only, regardless of Hamming.
    - Always return to IDLE. A 0 stop bit is never taken as a new start bit.
  - LONG: skip 39 bits, then go to LSTOP.
  - LSTOP: stop = 1 increments long_frame_count; stop = 0 increments stop_err_count. Return to IDLE.
- Counters saturate at all-ones and never wrap.
  - clear_counters zeroes all three counters.
  - clear_counters has priority over a simultaneous increment; the event is lost.
- chan_b_info, evt_count_reset and bcnt_reset change only on a valid frame. Errored and long frames leave them unchanged.

## Timing
- Reset: FSM = IDLE, shift register = 0, all outputs and counters = 0.
- Reset mid-frame aborts the frame. No strobe and no counter change result from the aborted frame.
- Latency: the stop bit is sampled on clock edge N; chan_b_valid and the new data are registered and high for exactly the cycle after edge N.
- Counter increments are visible the cycle after the stop bit is sampled.
- Back-to-back frames: the strobed bit right after a stop bit may be the next start bit. Zero idle bits are required.
- With b_strobe held high, the start bit at cycle T0 gives chan_b_valid at T0+16.
- Gaps (b_strobe=0) anywhere inside a frame stall the FSM and counter without error. There is no timeout.
- chan_b_valid never asserts on two consecutive cycles.

## Test plan
- Short frame 0x02, check bits H4..H0=01101, b_strobe always high -> chan_b_valid at T0+16, evt_count_reset=1, bcnt_reset=0, chan_b_info=000000; all counters 0.
- Short frame 0xA8 (correct Hamming), then frame 0x02 immediately after with no idle bits -> two strobes 16 cycles apart; chan_b_info=101010 then 000000.
- Frame 0x02 with one check bit flipped -> no strobe; hamming_err_count=1; outputs keep their previous values.
- Short frame with stop bit 0, then idle 1s, then valid 0x0A -> stop_err_count=1; strobe for the 0x0A frame, with the 0 stop bit not treated as a start.
- Long frame (format bit 1, 39 random payload bits, stop 1) containing 0 bits, followed by a short 0x02 -> long_frame_count=1; no strobe for the long frame; one strobe for 0x02.
- b_strobe toggled 1/0 every cycle during a 0x02 frame, with reset asserted midway through a second frame -> first frame decodes at 2x latency; after reset all outputs are 0 and no strobe appears. Additionally, force 2^CNT_W+3 Hamming errors -> counter holds all-ones; clear_counters -> 0.

Source files
------------

// File: rtl/ttc_chanb_frame_decoder.sv
// TTC channel B frame decoder: frames short/long frames from the strobed bit
// stream, checks the short-frame Hamming code and publishes broadcast commands.
module ttc_chanb_frame_decoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             b_bit,
  input  logic             b_strobe,
  input  logic             clear_counters,
  output logic [5:0]       chan_b_info,
  output logic             evt_count_reset,
  output logic             bcnt_reset,
  output logic             chan_b_valid,
  output logic [CNT_W-1:0] hamming_err_count,
  output logic [CNT_W-1:0] stop_err_count,
  output logic [CNT_W-1:0] long_frame_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_FMT, S_SHORT, S_SSTOP, S_LONG, S_LSTOP
  } state_e;

  localparam logic [5:0]       SHORT_LAST = 6'd12;  // 8 data + 5 check bits
  localparam logic [5:0]       LONG_LAST  = 6'd38;  // 39 payload bits
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [5:0]       bit_cnt_q, bit_cnt_d;
  logic [12:0]      shift_q, shift_d;
  logic [7:0]       data_q;
  logic             valid_q;
  logic [CNT_W-1:0] ham_cnt_q, stop_cnt_q, long_cnt_q;

  logic             load_frame, inc_ham, inc_stop, inc_long;
  logic [7:0]       rx_data;
  logic [4:0]       rx_check;
  logic [3:0]       calc_lo;
  logic             calc_h4, ham_ok;

  // Received word: D7..D0 in the upper bits, H4..H0 in the lower bits.
  assign rx_data  = shift_q[12:5];
  assign rx_check = shift_q[4:0];
  assign calc_lo[0] = rx_data[0] ^ rx_data[1] ^ rx_data[2] ^ rx_data[3];
  assign calc_lo[1] = rx_data[0] ^ rx_data[4] ^ rx_data[5] ^ rx_data[6];
  assign calc_lo[2] = rx_data[1] ^ rx_data[2] ^ rx_data[4] ^ rx_data[5] ^ rx_data[7];
  assign calc_lo[3] = rx_data[1] ^ rx_data[3] ^ rx_data[4] ^ rx_data[6] ^ rx_data[7];
  assign calc_h4    = (^rx_data) ^ (^calc_lo);
  assign ham_ok     = ({calc_h4, calc_lo} == rx_check);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    return (inc && (v != '1)) ? v + CNT_ONE : v;
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
    end
  end

  // NOTE: every comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    if (b_strobe) begin
      unique case (state_q)
        S_IDLE:  if (!b_bit) state_d = S_FMT;
        S_FMT: begin
          bit_cnt_d = '0;
          state_d   = b_bit ? S_LONG : S_SHORT;
        end
        S_SHORT: begin
          shift_d   = {shift_q[11:0], b_bit};
          bit_cnt_d = bit_cnt_q + 6'd1;
          if (bit_cnt_q == SHORT_LAST) state_d = S_SSTOP;
        end
        S_LONG: begin
          bit_cnt_d = bit_cnt_q + 6'd1;
          if (bit_cnt_q == LONG_LAST) state_d = S_LSTOP;
        end
        // A stop bit of 0 is consumed here, never reinterpreted as a start.
        S_SSTOP, S_LSTOP: state_d = S_IDLE;
        default:          state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    load_frame = 1'b0;
    inc_ham    = 1'b0;
    inc_stop   = 1'b0;
    inc_long   = 1'b0;
    if (b_strobe) begin
      unique case (state_q)
        S_SSTOP: begin
          if (!b_bit)     inc_stop   = 1'b1;
          else if (ham_ok) load_frame = 1'b1;
          else            inc_ham    = 1'b1;
        end
        S_LSTOP: begin
          if (b_bit) inc_long = 1'b1;
          else       inc_stop = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= load_frame;
      if (load_frame) data_q <= rx_data;
    end
  end

  // Clear wins over a same-cycle increment; that event is dropped.
  always_ff @(posedge clk) begin
    if (reset || clear_counters) begin
      ham_cnt_q  <= '0;
      stop_cnt_q <= '0;
      long_cnt_q <= '0;
    end else begin
      ham_cnt_q  <= sat_inc(ham_cnt_q, inc_ham);
      stop_cnt_q <= sat_inc(stop_cnt_q, inc_stop);
      long_cnt_q <= sat_inc(long_cnt_q, inc_long);
    end
  end

  assign chan_b_info       = data_q[7:2];
  assign evt_count_reset   = data_q[1];
  assign bcnt_reset        = data_q[0];
  assign chan_b_valid      = valid_q;
  assign hamming_err_count = ham_cnt_q;
  assign stop_err_count    = stop_cnt_q;
  assign long_frame_count  = long_cnt_q;

endmodule

// File: tb/tb_ttc_chanb_frame_decoder.sv
// Self-checking bench for ttc_chanb_frame_decoder: directed vector table,
// hand-written corner sequences and randomized frames against a frame-level model.
module tb_ttc_chanb_frame_decoder;

  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset, b_bit, b_strobe, clear_counters;
  logic [5:0]       chan_b_info;
  logic             evt_count_reset, bcnt_reset, chan_b_valid;
  logic [CNT_W-1:0] hamming_err_count, stop_err_count, long_frame_count;

  ttc_chanb_frame_decoder #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .b_bit(b_bit), .b_strobe(b_strobe),
    .clear_counters(clear_counters), .chan_b_info(chan_b_info),
    .evt_count_reset(evt_count_reset), .bcnt_reset(bcnt_reset),
    .chan_b_valid(chan_b_valid), .hamming_err_count(hamming_err_count),
    .stop_err_count(stop_err_count), .long_frame_count(long_frame_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Strobe monitor, sampled on the falling edge.
  typedef struct { int cyc; logic [7:0] b; } strobe_t;
  strobe_t sq[$];
  logic    prev_v = 1'b0;
  int      dbl_valid = 0;
  always @(negedge clk) begin
    if (chan_b_valid === 1'b1) sq.push_back('{cyc, {chan_b_info, evt_count_reset, bcnt_reset}});
    if (prev_v === 1'b1 && chan_b_valid === 1'b1) dbl_valid++;
    prev_v = chan_b_valid;
  end

  // ---------------- reference model (frame level) ----------------
  logic [7:0] m_byte;
  int m_ham, m_stop, m_long;

  function automatic logic [4:0] ham_of(input logic [7:0] d);
    logic h0, h1, h2, h3, h4;
    h0 = d[0] ^ d[1] ^ d[2] ^ d[3];
    h1 = d[0] ^ d[4] ^ d[5] ^ d[6];
    h2 = d[1] ^ d[2] ^ d[4] ^ d[5] ^ d[7];
    h3 = d[1] ^ d[3] ^ d[4] ^ d[6] ^ d[7];
    h4 = (^d) ^ h0 ^ h1 ^ h2 ^ h3;
    return {h4, h3, h2, h1, h0};
  endfunction

  function automatic void model_reset();
    m_byte = 8'h00; m_ham = 0; m_stop = 0; m_long = 0;
  endfunction

  function automatic bit model_frame(input bit is_long, input logic [7:0] d,
                                     input logic [4:0] h, input bit stop, input bit clr);
    bit s = 1'b0;
    if (!stop)                m_stop = (m_stop < CMAX) ? m_stop + 1 : m_stop;
    else if (is_long)         m_long = (m_long < CMAX) ? m_long + 1 : m_long;
    else if (ham_of(d) == h) begin m_byte = d; s = 1'b1; end
    else                      m_ham = (m_ham < CMAX) ? m_ham + 1 : m_ham;
    if (clr) begin m_ham = 0; m_stop = 0; m_long = 0; end
    return s;
  endfunction

  // ---------------- stimulus helpers ----------------
  bit txq[$];

  function automatic void build_short(input logic [7:0] d, input logic [4:0] h, input bit stop);
    txq.delete();
    txq.push_back(1'b0); txq.push_back(1'b0);
    for (int i = 7; i >= 0; i--) txq.push_back(d[i]);
    for (int i = 4; i >= 0; i--) txq.push_back(h[i]);
    txq.push_back(stop);
  endfunction

  function automatic void build_long(input logic [38:0] pay, input bit stop);
    txq.delete();
    txq.push_back(1'b0); txq.push_back(1'b1);
    for (int i = 38; i >= 0; i--) txq.push_back(pay[i]);
    txq.push_back(stop);
  endfunction

  // mode 0: strobe every cycle, 1: strobe every other cycle, 2: random gaps
  task automatic send_txq(input int mode, input bit clr_last, output int t0, output int tl);
    t0 = 0; tl = 0;
    for (int i = 0; i < txq.size(); i++) begin
      int gap = 0;
      if (i > 0 && mode == 1) gap = 1;
      else if (i > 0 && mode == 2) gap = $urandom_range(0, 3);
      repeat (gap) begin
        @(negedge clk); b_strobe = 1'b0; b_bit = 1'($urandom);
      end
      @(negedge clk); b_bit = txq[i]; b_strobe = 1'b1;
      if (i == 0) t0 = cyc;
      if (i == txq.size() - 1) begin tl = cyc; clear_counters = clr_last; end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk); b_strobe = 1'b0; b_bit = 1'b1; clear_counters = 1'b0;
    end
  endtask

  task automatic check_state(input string name);
    check({name, "/brcst"}, {chan_b_info, evt_count_reset, bcnt_reset}, m_byte);
    check({name, "/ham_cnt"}, hamming_err_count, m_ham);
    check({name, "/stop_cnt"}, stop_err_count, m_stop);
    check({name, "/long_cnt"}, long_frame_count, m_long);
  endtask

  task automatic run_frame(input string name, input bit is_long, input logic [7:0] d,
                           input logic [4:0] h, input bit stop, input logic [38:0] pay,
                           input int mode, input bit clr);
    int t0, tl;
    bit s;
    if (is_long) build_long(pay, stop);
    else         build_short(d, h, stop);
    send_txq(mode, clr, t0, tl);
    idle(3);
    s = model_frame(is_long, d, h, stop, clr);
    check({name, "/strobes"}, sq.size(), s);
    if (s && sq.size() > 0) begin
      check({name, "/lat"}, sq[0].cyc, tl + 1);
      check({name, "/byte"}, sq[0].b, m_byte);
    end
    check_state(name);
    sq.delete();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [7:0] d; logic [4:0] h; logic stop;
    logic exp_v; logic [7:0] exp_b; int exp_ham; int exp_stop;
  } vec_t;
  vec_t vecs[7];

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    int t0, tl, t0a, t0b;
    bit s;
    logic [7:0] d;
    logic [4:0] h;
    logic [38:0] pay;

    vecs[0] = '{8'h02, 5'b01101, 1'b1, 1'b1, 8'h02, 0, 0};
    vecs[1] = '{8'hA8, 5'b10011, 1'b1, 1'b1, 8'hA8, 0, 0};
    vecs[2] = '{8'h02, 5'b01100, 1'b1, 1'b0, 8'hA8, 1, 0};
    vecs[3] = '{8'h55, 5'b10010, 1'b0, 1'b0, 8'hA8, 1, 1};
    vecs[4] = '{8'h0A, 5'b10100, 1'b1, 1'b1, 8'h0A, 1, 1};
    vecs[5] = '{8'hFF, 5'b01100, 1'b1, 1'b1, 8'hFF, 1, 1};
    vecs[6] = '{8'hFF, 5'b11100, 1'b1, 1'b0, 8'hFF, 2, 1};

    reset = 1'b1; b_bit = 1'b1; b_strobe = 1'b0; clear_counters = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset/valid", chan_b_valid, 1'b0);
    check("reset/brcst", {chan_b_info, evt_count_reset, bcnt_reset}, 8'h00);
    check("reset/ham_cnt", hamming_err_count, 0);
    check("reset/stop_cnt", stop_err_count, 0);
    check("reset/long_cnt", long_frame_count, 0);
    reset = 1'b0;
    idle(2);
    sq.delete();

    // Table: strobe every cycle, expected results written out by hand.
    for (int i = 0; i < 7; i++) begin
      build_short(vecs[i].d, vecs[i].h, vecs[i].stop);
      send_txq(0, 1'b0, t0, tl);
      idle(3);
      s = model_frame(1'b0, vecs[i].d, vecs[i].h, vecs[i].stop, 1'b0);
      check($sformatf("vec%0d/strobes", i), sq.size(), vecs[i].exp_v);
      if (vecs[i].exp_v && sq.size() > 0) begin
        check($sformatf("vec%0d/lat_t0", i), sq[0].cyc - t0, 16);
        check($sformatf("vec%0d/byte", i), sq[0].b, vecs[i].exp_b);
      end
      check($sformatf("vec%0d/brcst", i), {chan_b_info, evt_count_reset, bcnt_reset}, vecs[i].exp_b);
      check($sformatf("vec%0d/ham_cnt", i), hamming_err_count, vecs[i].exp_ham);
      check($sformatf("vec%0d/stop_cnt", i), stop_err_count, vecs[i].exp_stop);
      check($sformatf("vec%0d/long_cnt", i), long_frame_count, 0);
      sq.delete();
    end

    // Back-to-back short frames with zero idle bits.
    build_short(8'hA8, ham_of(8'hA8), 1'b1);
    send_txq(0, 1'b0, t0a, tl);
    build_short(8'h02, ham_of(8'h02), 1'b1);
    send_txq(0, 1'b0, t0b, tl);
    idle(3);
    s = model_frame(1'b0, 8'hA8, ham_of(8'hA8), 1'b1, 1'b0);
    s = model_frame(1'b0, 8'h02, ham_of(8'h02), 1'b1, 1'b0);
    check("b2b/strobes", sq.size(), 2);
    if (sq.size() == 2) begin
      check("b2b/lat_first", sq[0].cyc - t0a, 16);
      check("b2b/spacing", sq[1].cyc - sq[0].cyc, 16);
      check("b2b/info_first", {26'd0, sq[0].b[7:2]}, 6'b101010);
      check("b2b/info_second", {26'd0, sq[1].b[7:2]}, 6'b000000);
    end
    check_state("b2b");
    sq.delete();

    // Zero stop bit followed by idle ones must not start a frame.
    run_frame("stop0", 1'b0, 8'h3C, ham_of(8'h3C), 1'b0, '0, 0, 1'b0);
    txq.delete();
    repeat (3) txq.push_back(1'b1);
    send_txq(0, 1'b0, t0, tl);
    run_frame("after_stop0", 1'b0, 8'h0A, ham_of(8'h0A), 1'b1, '0, 0, 1'b0);

    // Long frame with zeros in the payload, then a short frame.
    pay = 39'({$urandom, $urandom});
    pay[20] = 1'b0; pay[3] = 1'b0;
    run_frame("long", 1'b1, 8'h00, 5'h00, 1'b1, pay, 0, 1'b0);
    run_frame("after_long", 1'b0, 8'h02, ham_of(8'h02), 1'b1, '0, 0, 1'b0);

    // Randomized frames with random strobe gaps and idle bits.
    for (int n = 0; n < 40; n++) begin
      int kind, mode;
      kind = $urandom_range(0, 4);
      mode = ($urandom_range(0, 1) == 1) ? 2 : 0;
      d    = 8'($urandom);
      pay  = 39'({$urandom, $urandom});
      h    = ham_of(d);
      if ($urandom_range(0, 3) == 0) begin
        txq.delete();
        repeat ($urandom_range(1, 4)) txq.push_back(1'b1);
        send_txq(mode, 1'b0, t0, tl);
      end
      case (kind)
        0: run_frame($sformatf("rnd%0d_ok", n), 1'b0, d, h, 1'b1, pay, mode, 1'b0);
        1: run_frame($sformatf("rnd%0d_ham", n), 1'b0, d,
                     h ^ (5'b00001 << $urandom_range(0, 4)), 1'b1, pay, mode, 1'b0);
        2: run_frame($sformatf("rnd%0d_stop", n), 1'b0, d, 5'($urandom), 1'b0, pay, mode, 1'b0);
        3: run_frame($sformatf("rnd%0d_long", n), 1'b1, d, h, 1'b1, pay, mode, 1'b0);
        default: run_frame($sformatf("rnd%0d_lstop", n), 1'b1, d, h, 1'b0, pay, mode, 1'b0);
      endcase
    end

    // Alternating strobe: decode at doubled latency.
    build_short(8'h02, ham_of(8'h02), 1'b1);
    send_txq(1, 1'b0, t0, tl);
    idle(3);
    s = model_frame(1'b0, 8'h02, ham_of(8'h02), 1'b1, 1'b0);
    check("alt/strobes", sq.size(), 1);
    if (sq.size() > 0) begin
      check("alt/lat_t0", sq[0].cyc - t0, 31);
      check("alt/byte", sq[0].b, 8'h02);
    end
    check_state("alt");
    sq.delete();

    // Reset in the middle of a second frame.
    build_short(8'hA8, ham_of(8'hA8), 1'b1);
    while (txq.size() > 7) void'(txq.pop_back());
    send_txq(1, 1'b0, t0, tl);
    @(negedge clk); reset = 1'b1; b_strobe = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
    idle(3);
    check("midreset/strobes", sq.size(), 0);
    check("midreset/valid", chan_b_valid, 1'b0);
    check_state("midreset");
    txq.delete();
    repeat (20) txq.push_back(1'b1);
    send_txq(0, 1'b0, t0, tl);
    idle(3);
    check("midreset_ones/strobes", sq.size(), 0);
    check_state("midreset_ones");
    sq.delete();

    // Saturation: 2^CNT_W + 3 Hamming errors.
    for (int n = 0; n < CMAX + 4; n++) begin
      d = 8'($urandom);
      run_frame($sformatf("sat%0d", n), 1'b0, d, ham_of(d) ^ 5'b00100, 1'b1, '0, 0, 1'b0);
    end
    check("sat/all_ones", hamming_err_count, CMAX);

    // Clear on the same cycle as an error event: clear wins.
    run_frame("clr_prio", 1'b0, 8'h3C, ham_of(8'h3C) ^ 5'b10000, 1'b1, '0, 0, 1'b1);
    check("clr_prio/ham_zero", hamming_err_count, 0);

    // Plain clear.
    run_frame("pre_clr", 1'b0, 8'h11, 5'h00, 1'b0, '0, 0, 1'b0);
    @(negedge clk); clear_counters = 1'b1;
    @(negedge clk); clear_counters = 1'b0;
    m_ham = 0; m_stop = 0; m_long = 0;
    idle(1);
    check_state("clear");

    check("no_back_to_back_valid", dbl_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
